// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the round-robin regbus arbiter.
// The watchdog (REG_RR_ARBITER_TIMEOUT_EN) uses DefaultTimeoutCycles.
package reg_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned DefaultTimeoutCycles = 256;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// File: rtl/reg_rr_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: scans valid_i upward from ptr_i,
// wrapping modulo NumPorts, and reports the first set index.
module rr_pick #(
    parameter int unsigned NumPorts = 2,
    parameter int unsigned IdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic [NumPorts-1:0] valid_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                any_valid_o
);

    logic [IdxWidth-1:0] cand;

    always_comb begin
        idx_o       = '0;
        any_valid_o = 1'b0;
        cand        = ptr_i;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (!any_valid_o && valid_i[cand]) begin
                idx_o       = cand;
                any_valid_o = 1'b1;
            end
            // Explicit compare keeps non-power-of-two port counts wrapping correctly.
            cand = (cand == IdxWidth'(NumPorts - 1)) ? '0 : cand + IdxWidth'(1);
        end
    end

endmodule

// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter sharing one regbus slave among NumPorts requesters; grant is held
// until the slave answers ready. Define REG_RR_ARBITER_TIMEOUT_EN for the hang watchdog.
module reg_rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NumPorts      = 2,
    parameter int unsigned TimeoutCycles = DefaultTimeoutCycles,
    parameter type         req_t         = reg_req_t,
    parameter type         rsp_t         = reg_rsp_t,
    parameter int unsigned IdxWidth      = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  req_t       [NumPorts-1:0] in_req_i,
    output rsp_t       [NumPorts-1:0] in_rsp_o,
    output req_t                      out_req_o,
    input  rsp_t                      out_rsp_i,
    output logic       [IdxWidth-1:0] gnt_idx_o,
    output logic                      busy_o
`ifdef REG_RR_ARBITER_TIMEOUT_EN
    ,
    output logic                      timeout_o
`endif
);

    arb_state_e          state_q, state_d;
    logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0] gnt_q, gnt_d;
    logic [IdxWidth-1:0] gnt_inc;
    logic [NumPorts-1:0] req_valid;
    logic [IdxWidth-1:0] pick_idx;
    logic                pick_any;
    logic                abort;
    logic                done;

    for (genvar k = 0; k < NumPorts; k++) begin : g_valid
        assign req_valid[k] = in_req_i[k].valid;
    end

    rr_pick #(
        .NumPorts (NumPorts),
        .IdxWidth (IdxWidth)
    ) u_rr_pick (
        .valid_i     (req_valid),
        .ptr_i       (rr_ptr_q),
        .idx_o       (pick_idx),
        .any_valid_o (pick_any)
    );

    assign gnt_inc = (gnt_q == IdxWidth'(NumPorts - 1)) ? '0 : gnt_q + IdxWidth'(1);

`ifdef REG_RR_ARBITER_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                timeout_q, timeout_d;

    assign abort = (state_q == BUSY) && !out_rsp_i.ready &&
                   (cnt_q == CntWidth'(TimeoutCycles - 1));

    // Counter idles at zero, so the first BUSY cycle always sees a cleared count.
    always_comb begin
        cnt_d     = '0;
        timeout_d = timeout_q | abort;
        if (state_q == BUSY && !done) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign abort = 1'b0;
`endif

    assign done = (state_q == BUSY) && (out_rsp_i.ready || abort);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d  = IDLE;
                    rr_ptr_d = gnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Only the granted port ever sees the slave; everything else reads as zero.
    always_comb begin
        out_req_o = '0;
        in_rsp_o  = '0;
        if (state_q == BUSY) begin
            out_req_o       = in_req_i[gnt_q];
            out_req_o.valid = !abort;
            in_rsp_o[gnt_q] = out_rsp_i;
            if (abort) begin
                in_rsp_o[gnt_q].ready = 1'b1;
                in_rsp_o[gnt_q].error = 1'b1;
                in_rsp_o[gnt_q].rdata = '0;
            end
        end
    end

    assign busy_o    = (state_q == BUSY);
    assign gnt_idx_o = gnt_q;

`ifndef SYNTHESIS
    if (NumPorts < 2) begin : g_bad_ports
        $error("reg_rr_arbiter needs NumPorts >= 2");
    end
    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("reg_rr_arbiter needs TimeoutCycles >= 2");
    end

    valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == BUSY) |-> in_req_i[gnt_q].valid)
        else $error("granted requester dropped valid before ready");
`endif

endmodule
